// File: rtl/bbot_drive_command_scheduler.sv
// bbot_drive_command_scheduler: SPI drive commands to slewed servo pulse widths with watchdog failsafe
`timescale 1ns/1ps
module bbot_drive_command_scheduler #(
  parameter int ZERO_PULSES   = 75000,
  parameter int RANGE_MULT    = 250,
  parameter int PERIOD_CYCLES = 1100000,
  parameter int SLEW_STEP     = 2500,
  parameter int WDOG_CYCLES   = 25000000
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  output logic        period_start,
  output logic [31:0] left_pulse_width,
  output logic [31:0] right_pulse_width,
  output logic        motor_src_sel,
  output logic        cam_src_sel,
  output logic        wdog_tripped,
  output logic        sat_flag,
  output logic [1:0]  state
);
  localparam logic [31:0] ZP = 32'(ZERO_PULSES);
  localparam logic [31:0] PL = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] WD = 32'(WDOG_CYCLES);
  localparam logic [31:0] ST = 32'(SLEW_STEP);
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FAILSAFE = 2'd2} state_t;
  state_t st;
  logic [31:0] cnt, wdog, tgt_l, tgt_r;
  logic [7:0] last_seq;
  logic signed [7:0] pl, pr;
  logic acc, expire, sat_l, sat_r, unused_bits;
  function automatic logic signed [7:0] clamp(input logic signed [7:0] p);
    return p > 8'sd100 ? 8'sd100 : p < -8'sd100 ? -8'sd100 : p;
  endfunction
  function automatic logic [31:0] tgt_of(input logic signed [7:0] p);
    return 32'(ZERO_PULSES + int'(p) * RANGE_MULT);
  endfunction
  function automatic logic [31:0] slew(input logic [31:0] cur, input logic [31:0] tgt);
    return tgt > cur ? (tgt - cur > ST ? cur + ST : tgt) : (cur - tgt > ST ? cur - ST : tgt);
  endfunction
  assign state = st;
  assign pl = frame_data[15:8];
  assign pr = frame_data[23:16];
  assign sat_l = pl > 8'sd100 || pl < -8'sd100;
  assign sat_r = pr > 8'sd100 || pr < -8'sd100;
  assign unused_bits = ^frame_data[7:2];
  assign acc = frame_valid && (st == IDLE || frame_data[31:24] != last_seq);
  // expiry is the cycle whose decrement would reach zero; a coincident frame wins
  assign expire = st == ACTIVE && wdog <= 32'd1 && !acc;
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      st                <= IDLE;
      cnt               <= '0;
      period_start      <= 1'b0;
      left_pulse_width  <= ZP;
      right_pulse_width <= ZP;
      tgt_l             <= ZP;
      tgt_r             <= ZP;
      motor_src_sel     <= 1'b0;
      cam_src_sel       <= 1'b0;
      wdog_tripped      <= 1'b0;
      sat_flag          <= 1'b0;
      wdog              <= WD;
      last_seq          <= '0;
    end else begin
      cnt          <= cnt == PL ? '0 : cnt + 32'd1;
      period_start <= cnt == PL;
      // slew uses the target held before any frame accepted this same cycle
      if (period_start) begin
        left_pulse_width  <= slew(left_pulse_width, tgt_l);
        right_pulse_width <= slew(right_pulse_width, tgt_r);
      end
      if (acc) begin
        st            <= ACTIVE;
        wdog          <= WD;
        last_seq      <= frame_data[31:24];
        tgt_l         <= tgt_of(clamp(pl));
        tgt_r         <= tgt_of(clamp(pr));
        motor_src_sel <= frame_data[0];
        cam_src_sel   <= frame_data[1];
        wdog_tripped  <= 1'b0;
        sat_flag      <= sat_flag | sat_l | sat_r;
      end else if (expire) begin
        st            <= FAILSAFE;
        wdog          <= '0;
        tgt_l         <= ZP;
        tgt_r         <= ZP;
        motor_src_sel <= 1'b1;
        cam_src_sel   <= 1'b0;
        wdog_tripped  <= 1'b1;
      end else if (st == ACTIVE) begin
        wdog <= wdog - 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_bbot_drive_command_scheduler.sv
// tb_bbot_drive_command_scheduler: directed checks of slew, clamping, watchdog and reset behaviour
`timescale 1ns/1ps
module tb_bbot_drive_command_scheduler;
  logic clock = 1'b0, reset_l = 1'b0, frame_valid = 1'b0;
  logic [31:0] frame_data = '0;
  logic period_start, motor_src_sel, cam_src_sel, wdog_tripped, sat_flag;
  logic [31:0] left_pulse_width, right_pulse_width;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  bbot_drive_command_scheduler #(.PERIOD_CYCLES(100), .WDOG_CYCLES(1000)) dut (
    .clock(clock), .reset_l(reset_l), .frame_valid(frame_valid), .frame_data(frame_data),
    .period_start(period_start), .left_pulse_width(left_pulse_width),
    .right_pulse_width(right_pulse_width), .motor_src_sel(motor_src_sel),
    .cam_src_sel(cam_src_sel), .wdog_tripped(wdog_tripped), .sat_flag(sat_flag), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [7:0] seq, input logic [7:0] r, input logic [7:0] l, input logic [1:0] src);
    return {seq, r, l, 6'd0, src};
  endfunction
  task automatic send(input logic [31:0] d);
    @(negedge clock);
    frame_valid = 1'b1;
    frame_data = d;
    @(posedge clock);
    #1 frame_valid = 1'b0;
  endtask
  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!period_start && n < 300);
    chk("ps_timeout", 32'(n < 300), 32'd1);
  endtask
  task automatic next_period();
    wait_ps();
    @(negedge clock);
  endtask
  task automatic first_ps(input string tag);
    int n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (!period_start && n < 300);
    chk(tag, 32'(n), 32'd100);
  endtask
  initial begin
    int k;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_left", left_pulse_width, 32'd75000);
    chk("rst_right", right_pulse_width, 32'd75000);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_motor", 32'(motor_src_sel), 32'd0);
    chk("rst_cam", 32'(cam_src_sel), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_trip", 32'(wdog_tripped), 32'd0);
    @(negedge clock) reset_l = 1'b1;
    first_ps("first_ps");
    repeat (5) @(negedge clock);
    send(mk(8'h01, 8'h14, 8'h0A, 2'b01));
    chk("acc_state", 32'(state), 32'd1);
    chk("acc_motor", 32'(motor_src_sel), 32'd1);
    chk("acc_cam", 32'(cam_src_sel), 32'd0);
    chk("acc_left_hold", left_pulse_width, 32'd75000);
    next_period();
    chk("p1_left", left_pulse_width, 32'd77500);
    chk("p1_right", right_pulse_width, 32'd77500);
    next_period();
    chk("p2_left", left_pulse_width, 32'd77500);
    chk("p2_right", right_pulse_width, 32'd80000);
    send(mk(8'h02, 8'h14, 8'h9C, 2'b01));
    chk("neg100_sat", 32'(sat_flag), 32'd0);
    next_period();
    chk("neg100_left", left_pulse_width, 32'd75000);
    send(mk(8'h03, 8'h14, 8'h80, 2'b01));
    chk("neg128_sat", 32'(sat_flag), 32'd1);
    for (int i = 0; i < 12; i++) begin
      next_period();
      send(mk(8'(8'h40 + i), 8'h14, 8'h80, 2'b01));
    end
    chk("clamp_left", left_pulse_width, 32'd50000);
    chk("clamp_right", right_pulse_width, 32'd80000);
    chk("clamp_sat_sticky", 32'(sat_flag), 32'd1);
    send(mk(8'h60, 8'h28, 8'h28, 2'b11));
    chk("cam_on", 32'(cam_src_sel), 32'd1);
    repeat (299) @(posedge clock);
    send(mk(8'h60, 8'h28, 8'h28, 2'b11));
    k = 300;
    while (state != 2'd2 && k < 2000) begin
      @(posedge clock);
      #1 k++;
    end
    chk("fs_delay", 32'(k), 32'd1000);
    chk("fs_trip", 32'(wdog_tripped), 32'd1);
    chk("fs_cam", 32'(cam_src_sel), 32'd0);
    chk("fs_motor", 32'(motor_src_sel), 32'd1);
    send(mk(8'h60, 8'h28, 8'h28, 2'b11));
    chk("fs_dup_ignored", 32'(state), 32'd2);
    repeat (6) next_period();
    chk("fs_left", left_pulse_width, 32'd75000);
    chk("fs_right", right_pulse_width, 32'd75000);
    send(mk(8'h70, 8'h00, 8'h00, 2'b01));
    chk("recover_state", 32'(state), 32'd1);
    chk("recover_trip", 32'(wdog_tripped), 32'd0);
    repeat (999) @(posedge clock);
    send(mk(8'h71, 8'h00, 8'h00, 2'b01));
    chk("edge_state", 32'(state), 32'd1);
    chk("edge_trip", 32'(wdog_tripped), 32'd0);
    repeat (999) @(posedge clock);
    #1 chk("wd_999", 32'(state), 32'd1);
    @(posedge clock);
    #1 chk("wd_1000", 32'(state), 32'd2);
    send(mk(8'h72, 8'h00, 8'h00, 2'b01));
    wait_ps();
    frame_valid = 1'b1;
    frame_data = mk(8'h73, 8'h64, 8'h64, 2'b01);
    @(posedge clock);
    #1 frame_valid = 1'b0;
    chk("coinc_left", left_pulse_width, 32'd75000);
    chk("coinc_right", right_pulse_width, 32'd75000);
    next_period();
    chk("coinc_next_left", left_pulse_width, 32'd77500);
    next_period();
    chk("slew_left", left_pulse_width, 32'd80000);
    repeat (20) @(negedge clock);
    #2 reset_l = 1'b0;
    #1;
    chk("mid_rst_left", left_pulse_width, 32'd75000);
    chk("mid_rst_right", right_pulse_width, 32'd75000);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_sat", 32'(sat_flag), 32'd0);
    chk("mid_rst_motor", 32'(motor_src_sel), 32'd0);
    @(negedge clock) reset_l = 1'b1;
    first_ps("first_ps_after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bbot_drive_command_scheduler.md
BBOT_DRIVE_COMMAND_SCHEDULER -- requirements
Module: bbot_drive_command_scheduler

Interface
REQ-001 SHALL have parameter ZERO_PULSES, default 75000: neutral pulse width in clock cycles (1.5 ms at 50 MHz).
REQ-002 SHALL have parameter RANGE_MULT, default 250: clock cycles per percent of command.
REQ-003 SHALL have parameter PERIOD_CYCLES, default 1100000: servo frame period in clock cycles (22 ms).
REQ-004 SHALL have parameter SLEW_STEP, default 2500: maximum pulse-width change per period, in cycles.
REQ-005 SHALL have parameter WDOG_CYCLES, default 25000000: command timeout in clock cycles (500 ms).
REQ-006 SHALL have port clock, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_l, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port frame_valid, input, 1 bit: one-cycle strobe marking a new SPI command word.
REQ-009 SHALL have port frame_data, input, 32 bits: [0] motor_src, [1] cam_src, [15:8] left percent (signed int8), [23:16] right percent (signed int8), [31:24] sequence number.
REQ-010 SHALL have port period_start, output, 1 bit: one-cycle pulse at the start of each servo period.
REQ-011 SHALL have ports left_pulse_width and right_pulse_width, outputs, 32 bits each: pulse widths driven to the pulse generators.
REQ-012 SHALL have ports motor_src_sel and cam_src_sel, outputs, 1 bit each: 1 = FPGA generator, 0 = RC receiver.
REQ-013 SHALL have port wdog_tripped, output, 1 bit: high while in FAILSAFE.
REQ-014 SHALL have port sat_flag, output, 1 bit: sticky flag, set when any accepted percent is clamped.
REQ-015 SHALL have port state, output, 2 bits: 0 IDLE, 1 ACTIVE, 2 FAILSAFE.

Function
REQ-016 Period counter SHALL count 0..PERIOD_CYCLES-1 and wrap; period_start SHALL be high in the cycle the counter equals 0.
REQ-017 A frame SHALL be accepted when frame_valid=1 and either state=IDLE or the sequence number differs from the last accepted one; otherwise the frame SHALL be ignored.
REQ-018 On acceptance, each percent SHALL be clamped to [-100,+100], setting sat_flag if clamped; target = ZERO_PULSES + pct*RANGE_MULT, computed signed, range 50000..100000; the target register and src_sel outputs SHALL update one cycle after acceptance.
REQ-019 Pulse-width outputs SHALL change only in the cycle after period_start, moving from their current value toward target by min(|target-current|, SLEW_STEP).
REQ-020 A frame accepted in the same cycle as period_start SHALL NOT affect that period's slew step; it takes effect at the next period_start.
REQ-021 Watchdog SHALL reload to WDOG_CYCLES on every accepted frame and decrement by 1 per cycle in ACTIVE; it SHALL never underflow.
REQ-022 FSM: IDLE->ACTIVE on accepted frame; ACTIVE->FAILSAFE when the watchdog reaches 0; FAILSAFE->ACTIVE on accepted frame; no other transitions.
REQ-023 Watchdog expiry and frame acceptance in the same cycle SHALL resolve to the frame: remain ACTIVE and reload.
REQ-024 On entry to FAILSAFE, both targets SHALL be forced to ZERO_PULSES (slewed per REQ-019), motor_src_sel SHALL be held at 1, cam_src_sel SHALL be forced to 0, and wdog_tripped=1.
REQ-025 In IDLE, targets SHALL equal ZERO_PULSES and both src_sel outputs SHALL be 0.

Reset
REQ-026 reset_l=0 SHALL asynchronously force: state=IDLE, period counter=0, period_start=0, both pulse widths=ZERO_PULSES, both targets=ZERO_PULSES, src_sel outputs=0, wdog_tripped=0, sat_flag=0, watchdog=WDOG_CYCLES, last sequence number cleared.
REQ-027 Reset asserted mid-period or mid-slew SHALL abandon the operation; after release, the first period_start SHALL occur PERIOD_CYCLES cycles after the first clock edge.

Verification (bench parameters: PERIOD_CYCLES=100, WDOG_CYCLES=1000; other parameters at default)
REQ-028 Frame 0x01_14_0A_01 (seq 1, L=+10, R=+20, motor_src=1) from IDLE -> state=ACTIVE; targets 77500 and 80000; left reaches 77500 after 1 period; right reaches 77500 then 80000 over 2 periods.
REQ-029 Frame with L=0x9C (-100) followed by frame with L=0x80 (-128) -> first gives target 50000 with sat_flag=0; second is clamped to 50000 and sets sat_flag=1.
REQ-030 Repeat a frame with an unchanged sequence number -> ignored; watchdog not reloaded; FAILSAFE entered 1000 cycles after the last accepted frame; wdog_tripped=1; widths slew back to 75000; cam_src_sel=0.
REQ-031 Frame in the exact expiry cycle -> state stays ACTIVE; wdog_tripped stays 0.
REQ-032 Frame coincident with period_start -> widths unchanged at that step; the new target is applied at the following period_start.
REQ-033 Assert reset_l mid-slew (width 80000 heading to 100000) -> widths immediately 75000; state=IDLE; sat_flag=0.
